// File: rtl/mem_access_unit.sv
// Load/store unit for the EX stage: accepts one aligned access, runs it over a simple req/ack bus,
// formats load data and reports misalignment, read/write conflicts and bus timeouts on err.
module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [2:0]      funct3_r;
    logic [1:0]      addr_lo_r;
    logic            we_r;
    logic            bus_req_r, bus_req_s;
    logic            bus_we_r;
    logic [31:0]     bus_addr_r;
    logic [3:0]      bus_wstrb_r;
    logic [31:0]     bus_wdata_r;
    logic [31:0]     rdata_r;
    logic            done_r, done_s;
    logic            err_r, err_s;
    logic            stall_s;
    logic            latch_s;
    logic            rload_s;

    // funct3[1:0] encodes size (00 byte, 01 half, others word); funct3[2] selects zero extension
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        case (f3[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = a[0];
            default: bad = (a != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_strb(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s;
        case (f3[1:0])
            2'b00:   s = 4'b0001 << a;
            2'b01:   s = 4'b0011 << {a[1], 1'b0};
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            2'b11:   b = w[31:24];
            default: b = 8'h00;
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Next-state and control decode; ack takes priority over the timeout on the final REQ cycle
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        stall_s   = 1'b0;
        done_s    = 1'b0;
        err_s     = 1'b0;
        bus_req_s = 1'b0;
        latch_s   = 1'b0;
        rload_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (ex_valid && memread && memwrite) begin
                    err_s = 1'b1;
                end else if (ex_valid && (memread || memwrite)) begin
                    if (misaligned(funct3, addr[1:0])) begin
                        err_s = 1'b1;
                    end else begin
                        latch_s   = 1'b1;
                        stall_s   = 1'b1;
                        bus_req_s = 1'b1;
                        cnt_s     = '0;
                        state_s   = REQ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                stall_s = 1'b1;
                if (bus_ack) begin
                    done_s  = 1'b1;
                    rload_s = ~we_r;
                    state_s = DONE;
                end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else begin
                    cnt_s     = cnt_r + CW'(1);
                    bus_req_s = 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, bus and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            funct3_r    <= 3'b000;
            addr_lo_r   <= 2'b00;
            we_r        <= 1'b0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            bus_wstrb_r <= 4'b0000;
            bus_wdata_r <= 32'h0000_0000;
            rdata_r     <= 32'h0000_0000;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bus_req_r <= bus_req_s;
            done_r    <= done_s;
            err_r     <= err_s;
            if (latch_s) begin
                funct3_r    <= funct3;
                addr_lo_r   <= addr[1:0];
                we_r        <= memwrite;
                bus_we_r    <= memwrite;
                bus_addr_r  <= {addr[31:2], 2'b00};
                bus_wstrb_r <= memwrite ? lane_strb(funct3, addr[1:0]) : 4'b0000;
                bus_wdata_r <= lane_data(funct3, wdata);
            end else begin
                funct3_r <= funct3_r;
            end
            if (rload_s) begin
                rdata_r <= load_fmt(funct3_r, addr_lo_r, bus_rdata);
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // stall is combinational so the accept cycle itself freezes the pipeline
    assign stall     = stall_s & rst;
    assign done      = done_r;
    assign err       = err_r;
    assign rdata     = rdata_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wstrb = bus_wstrb_r;
    assign bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: loads, stores, alignment/conflict errors,
// timeout boundary and mid-transfer reset, with hand-computed expectations.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int vecs = 0;
    int miscmp = 0;

    mem_access_unit #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .memread   (memread),
        .memwrite  (memwrite),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wstrb (bus_wstrb),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        bus_ack  = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rd, input logic [31:0] exp);
        ex_valid = 1'b1; memread = 1'b1; memwrite = 1'b0; funct3 = f3; addr = a;
        #1;
        check({tag, "_accept_stall"}, stall, 1'b1);
        check({tag, "_accept_noreq"}, bus_req, 1'b0);
        tick();
        idle_inputs();
        bus_rdata = rd;
        bus_ack   = 1'b1;
        #1;
        check({tag, "_req"}, bus_req, 1'b1);
        check({tag, "_req_stall"}, stall, 1'b1);
        check({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
        tick();
        bus_ack = 1'b0;
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_done_stall"}, stall, 1'b0);
        check({tag, "_rdata"}, rdata, exp);
        tick();
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wd, input logic [31:0] keep_rdata);
        ex_valid = 1'b1; memread = 1'b0; memwrite = 1'b1; funct3 = f3; addr = a; wdata = wd;
        #1;
        check({tag, "_accept_stall"}, stall, 1'b1);
        tick();
        idle_inputs();
        addr = 32'hFFFF_FFFF; wdata = 32'h0000_0000; funct3 = 3'b000;
        #1;
        check({tag, "_req"}, bus_req, 1'b1);
        check({tag, "_we"}, bus_we, 1'b1);
        check({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
        check({tag, "_strb"}, bus_wstrb, exp_strb);
        check({tag, "_wdata"}, bus_wdata, exp_wd);
        tick();
        check({tag, "_hold_req"}, bus_req, 1'b1);
        check({tag, "_hold_strb"}, bus_wstrb, exp_strb);
        check({tag, "_hold_wdata"}, bus_wdata, exp_wd);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_rdata_kept"}, rdata, keep_rdata);
        tick();
    endtask

    initial begin
        rst = 1'b0; idle_inputs();
        funct3 = 3'b000; addr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0;
        tick(); tick();
        check("rst_stall", stall, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_req", bus_req, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_addr", bus_addr, 32'h0);
        rst = 1'b1;
        tick();

        run_load("lb_103", 3'b000, 32'h0000_0103, 32'h80FF_FFFF, 32'hFFFF_FF80);
        run_load("lhu_102", 3'b101, 32'h0000_0102, 32'h80FF_FFFF, 32'h0000_80FF);
        run_load("lh_102", 3'b001, 32'h0000_0102, 32'h80FF_FFFF, 32'hFFFF_80FF);
        run_load("lbu_101", 3'b100, 32'h0000_0101, 32'h80FF_FFFF, 32'h0000_00FF);
        run_load("lw_104", 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 32'hCAFE_F00D);

        run_store("sh_202", 3'b001, 32'h0000_0202, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 32'hCAFE_F00D);
        run_store("sb_001", 3'b000, 32'h0000_0001, 32'h0000_0055, 4'b0010, 32'h5555_5555, 32'hCAFE_F00D);
        run_store("sw_300", 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'hCAFE_F00D);

        // misaligned word load
        ex_valid = 1'b1; memread = 1'b1; funct3 = 3'b010; addr = 32'h0000_0101;
        #1;
        check("mis_stall", stall, 1'b0);
        tick();
        idle_inputs();
        check("mis_err", err, 1'b1);
        check("mis_req", bus_req, 1'b0);
        check("mis_done", done, 1'b0);
        tick();
        check("mis_err_pulse", err, 1'b0);
        check("mis_req_after", bus_req, 1'b0);

        // misaligned halfword store
        ex_valid = 1'b1; memwrite = 1'b1; funct3 = 3'b001; addr = 32'h0000_0203;
        tick();
        idle_inputs();
        check("mis_sh_err", err, 1'b1);
        check("mis_sh_req", bus_req, 1'b0);
        tick();

        // read/write conflict
        ex_valid = 1'b1; memread = 1'b1; memwrite = 1'b1; funct3 = 3'b010; addr = 32'h0000_0100;
        #1;
        check("conf_stall", stall, 1'b0);
        tick();
        idle_inputs();
        check("conf_err", err, 1'b1);
        check("conf_req", bus_req, 1'b0);
        tick();
        check("conf_err_pulse", err, 1'b0);

        // ignored requests and stray ack in IDLE
        ex_valid = 1'b0; memread = 1'b1; bus_ack = 1'b1;
        tick();
        check("ign_nv_req", bus_req, 1'b0);
        check("ign_nv_done", done, 1'b0);
        ex_valid = 1'b1; memread = 1'b0; memwrite = 1'b0;
        tick();
        check("ign_none_req", bus_req, 1'b0);
        check("ign_none_err", err, 1'b0);
        check("ign_ack_done", done, 1'b0);
        idle_inputs();
        tick();

        // timeout: 15 REQ cycles without ack
        ex_valid = 1'b1; memread = 1'b1; funct3 = 3'b010; addr = 32'h0000_0400;
        tick();
        idle_inputs();
        for (int k = 1; k <= 15; k++) begin
            check($sformatf("to_req_c%0d", k), bus_req, 1'b1);
            tick();
        end
        check("to_req_drop", bus_req, 1'b0);
        check("to_err", err, 1'b1);
        check("to_done", done, 1'b0);
        check("to_rdata_kept", rdata, 32'hCAFE_F00D);
        tick();
        check("to_err_pulse", err, 1'b0);

        // ack on the 15th REQ cycle counts as success
        ex_valid = 1'b1; memread = 1'b1; funct3 = 3'b010; addr = 32'h0000_0400;
        bus_rdata = 32'h1357_9BDF;
        tick();
        idle_inputs();
        for (int k = 1; k <= 14; k++) begin
            tick();
        end
        bus_ack = 1'b1;
        #1;
        check("ack15_req", bus_req, 1'b1);
        tick();
        bus_ack = 1'b0;
        check("ack15_done", done, 1'b1);
        check("ack15_err", err, 1'b0);
        check("ack15_rdata", rdata, 32'h1357_9BDF);
        tick();
        check("ack15_err_after", err, 1'b0);

        // reset in the middle of a store
        ex_valid = 1'b1; memwrite = 1'b1; funct3 = 3'b010; addr = 32'h0000_0500; wdata = 32'hA5A5_A5A5;
        tick();
        idle_inputs();
        tick();
        check("mrst_req_before", bus_req, 1'b1);
        rst = 1'b0;
        tick();
        check("mrst_req", bus_req, 1'b0);
        check("mrst_stall", stall, 1'b0);
        check("mrst_we", bus_we, 1'b0);
        check("mrst_addr", bus_addr, 32'h0);
        check("mrst_strb", bus_wstrb, 4'b0000);
        check("mrst_wdata", bus_wdata, 32'h0);
        check("mrst_rdata", rdata, 32'h0);
        check("mrst_done", done, 1'b0);
        check("mrst_err", err, 1'b0);
        rst = 1'b1;
        tick();

        run_load("lb_100", 3'b000, 32'h0000_0100, 32'h1234_567F, 32'h0000_007F);
        run_load("lh_100", 3'b001, 32'h0000_0100, 32'h0000_8001, 32'hFFFF_8001);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
